// File: rtl/conv_enc_pkg.sv
// ---------------------------------------------------------------------------
// conv_enc_pkg
// Shared constants and helpers for the 802.11a K=7 convolutional encoder
// with puncturing.
//   G0 / G1         generator polynomials for coded bits A and B.
//                   The MSB taps the incoming bit; the LSB taps the oldest
//                   stored bit.
//   RATE_*          rate codes as carried on iRate.
//   punctMask()     (rate, phase) -> which of A/B are transmitted.
//   phaseLast()     last phase value before the puncture counter wraps.
// ---------------------------------------------------------------------------
package conv_enc_pkg;

    localparam int K = 7;

    localparam logic [K-1:0] G0 = 7'o133;
    localparam logic [K-1:0] G1 = 7'o171;

    localparam logic [1:0] RATE_1_2 = 2'b00;
    localparam logic [1:0] RATE_2_3 = 2'b01;
    localparam logic [1:0] RATE_3_4 = 2'b10;

    localparam logic [1:0] PHASE_LAST_1_2 = 2'd0;
    localparam logic [1:0] PHASE_LAST_2_3 = 2'd1;
    localparam logic [1:0] PHASE_LAST_3_4 = 2'd2;

    typedef struct packed {
        logic keepA;
        logic keepB;
    } punctMask_t;

    // The reserved code 11 falls into the default branch and behaves as rate 1/2.
    function automatic punctMask_t punctMask(input logic [1:0] rate, input logic [1:0] phase);
        punctMask_t mask;
        mask = '{keepA: 1'b1, keepB: 1'b1};
        case (rate)
            RATE_2_3: begin
                if (phase == 2'd1) mask = '{keepA: 1'b1, keepB: 1'b0};
            end
            RATE_3_4: begin
                if (phase == 2'd1)      mask = '{keepA: 1'b1, keepB: 1'b0};
                else if (phase == 2'd2) mask = '{keepA: 1'b0, keepB: 1'b1};
            end
            default: mask = '{keepA: 1'b1, keepB: 1'b1};
        endcase
        return mask;
    endfunction

    function automatic logic [1:0] phaseLast(input logic [1:0] rate);
        logic [1:0] last;
        case (rate)
            RATE_2_3: last = PHASE_LAST_2_3;
            RATE_3_4: last = PHASE_LAST_3_4;
            default:  last = PHASE_LAST_1_2;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/conv_k7_core.sv
// ---------------------------------------------------------------------------
// conv_k7_core
// Six-bit shift register and generator XORs of the K=7 encoder. The coded
// pair (oA, oB) is a combinational function of the incoming bit and the
// stored history. The history advances only when iShift is high.
//   iClk    clock, rising edge
//   iRst_n  asynchronous active-low reset, clears the history
//   iClear  synchronous clear of the history (takes priority over iShift)
//   iShift  push iData into the history at the next edge
//   iData   incoming data bit
//   oA/oB   coded bits for G0/G1 using iData and the current history
// ---------------------------------------------------------------------------
module conv_k7_core
    import conv_enc_pkg::*;
(
    input  logic iClk,
    input  logic iRst_n,
    input  logic iClear,
    input  logic iShift,
    input  logic iData,
    output logic oA,
    output logic oB
);

    // history[0] is the newest stored bit and history[K-2] the oldest.
    logic [K-2:0] history;
    logic [K-1:0] window;

    // Lay the taps out so that the incoming bit sits at the generator MSB and
    // the oldest stored bit sits at the LSB. This lets each output be a plain
    // masked parity.
    always_comb begin
        window        = '0;
        window[K-1]   = iData;
        for (int i = 0; i < K-1; i++) begin
            window[K-2-i] = history[i];
        end
        oA = ^(window & G0);
        oB = ^(window & G1);
    end

    // History register: clear wins over shift so that a frame start always
    // begins from the all-zero state.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            history <= '0;
        end else if (iClear) begin
            history <= '0;
        end else if (iShift) begin
            history <= {history[K-3:0], iData};
        end
    end

endmodule

// File: rtl/conv_encoder_punct.sv
// ---------------------------------------------------------------------------
// conv_encoder_punct
// 802.11a K=7 convolutional encoder (133o/171o) with puncturing to rates
// 1/2, 2/3 and 3/4. The encoder takes serial bits on a valid/ready input and
// emits the punctured coded stream on a valid/ready output.
//   iClk    clock, rising edge
//   iRst_n  asynchronous active-low reset
//   iEN     global enable; when low, all state freezes and both handshakes idle
//   iClear  frame start: clears state and latches iRate
//   iRate   00=1/2, 01=2/3, 10=3/4, 11 acts as 1/2
//   iData   serial data bit
//   iValid  iData valid
//   oReady  encoder accepts iData this cycle
//   oData   coded serial bit (A before B)
//   oValid  oData valid
//   iReady  downstream accepts oData
//   oBusy   coded bits still held in the output buffer
// ---------------------------------------------------------------------------
module conv_encoder_punct
    import conv_enc_pkg::*;
(
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iEN,
    input  logic       iClear,
    input  logic [1:0] iRate,
    input  logic       iData,
    input  logic       iValid,
    output logic       oReady,
    output logic       oData,
    output logic       oValid,
    input  logic       iReady,
    output logic       oBusy
);

    logic [1:0] rateReg;
    logic [1:0] phase;
    logic [1:0] phaseNext;
    logic       bufA;
    logic       bufB;
    logic       pendA;
    logic       pendB;
    logic       codedA;
    logic       codedB;
    logic       consume;
    logic       accept;
    logic       clearEn;
    punctMask_t mask;

    // A clear only takes effect while the block is enabled.
    assign clearEn = iEN & iClear;

    conv_k7_core uCore (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iClear (clearEn),
        .iShift (accept),
        .iData  (iData),
        .oA     (codedA),
        .oB     (codedB)
    );

    // Handshake decode. A new input is accepted only if its coded bits fit in
    // the buffer. This happens when the buffer is empty or when the single
    // remaining bit leaves this cycle. oReady is forced low during reset so
    // that nothing is accepted while the state is held cleared.
    always_comb begin
        oValid  = iEN & (pendA | pendB);
        oData   = pendA ? bufA : bufB;
        oBusy   = pendA | pendB;
        consume = oValid & iReady;
        oReady  = iRst_n & iEN & ~iClear &
                  (~(pendA | pendB) | ((pendA ^ pendB) & iReady));
        accept  = iValid & oReady;
        mask    = punctMask(rateReg, phase);
        phaseNext = (phase >= phaseLast(rateReg)) ? 2'd0 : phase + 2'd1;
    end

    // Frame state and holding buffer. A clear discards anything pending.
    // An accept overwrites the buffer. This is safe because an accept only
    // happens when the buffer is empty or its last bit is leaving now.
    // Otherwise a consume retires A first and then B.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rateReg <= RATE_1_2;
            phase   <= 2'd0;
            bufA    <= 1'b0;
            bufB    <= 1'b0;
            pendA   <= 1'b0;
            pendB   <= 1'b0;
        end else if (iEN) begin
            if (iClear) begin
                rateReg <= iRate;
                phase   <= 2'd0;
                bufA    <= 1'b0;
                bufB    <= 1'b0;
                pendA   <= 1'b0;
                pendB   <= 1'b0;
            end else if (accept) begin
                bufA  <= codedA;
                bufB  <= codedB;
                pendA <= mask.keepA;
                pendB <= mask.keepB;
                phase <= phaseNext;
            end else if (consume) begin
                if (pendA) begin
                    pendA <= 1'b0;
                end else begin
                    pendB <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_punct.sv
// ---------------------------------------------------------------------------
// tb_conv_encoder_punct
// Directed bench for conv_encoder_punct. A table of frames (rate, input
// bits, expected coded bits, expected accept span) is streamed with iReady
// held high. Hand-written sequences then cover backpressure, a mid-frame
// clear, an enable freeze and a mid-frame reset.
// ---------------------------------------------------------------------------
module tb_conv_encoder_punct;

    logic       iClk = 1'b0;
    logic       iRst_n;
    logic       iEN;
    logic       iClear;
    logic [1:0] iRate;
    logic       iData;
    logic       iValid;
    logic       iReady;
    logic       oReady;
    logic       oData;
    logic       oValid;
    logic       oBusy;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        logic [1:0]  rate;
        int          nIn;
        logic [0:15] inBits;
        int          nOut;
        logic [0:15] outBits;
        int          span;
    } frameVec_t;

    frameVec_t frames [5];

    always #5 iClk = ~iClk;

    conv_encoder_punct dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iEN    (iEN),
        .iClear (iClear),
        .iRate  (iRate),
        .iData  (iData),
        .iValid (iValid),
        .oReady (oReady),
        .oData  (oData),
        .oValid (oValid),
        .iReady (iReady),
        .oBusy  (oBusy)
    );

    // Safety net in case a handshake never completes.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vecCount++;
        if (actual != expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then let the combinational
    // outputs settle before the caller samples them.
    task automatic applyStimulus(input logic en, input logic clr, input logic [1:0] rate,
                                 input logic valid, input logic data, input logic ready);
        @(negedge iClk);
        iEN    = en;
        iClear = clr;
        iRate  = rate;
        iValid = valid;
        iData  = data;
        iReady = ready;
        #1;
    endtask

    task automatic clearFrame(input logic [1:0] rate);
        applyStimulus(1'b1, 1'b1, rate, 1'b0, 1'b0, 1'b1);
        checkOutput("clearReady", int'(oReady), 0);
    endtask

    // Stream nIn bits with iReady high. Each emitted bit is checked against
    // the expected list, and the first-to-last accept distance is checked
    // against the expected throughput. iRate is driven to a different value
    // throughout to show that it is ignored mid-frame.
    task automatic streamBits(input string tag, input int nIn, input logic [0:15] inBits,
                              input int nOut, input logic [0:15] outBits, input int span);
        int inIdx;
        int outIdx;
        int cyc;
        int firstAcc;
        int lastAcc;
        inIdx    = 0;
        outIdx   = 0;
        cyc      = 0;
        firstAcc = -1;
        lastAcc  = -1;
        while ((inIdx < nIn || outIdx < nOut) && cyc < 200) begin
            applyStimulus(1'b1, 1'b0, 2'b01, (inIdx < nIn),
                          (inIdx < nIn) ? inBits[inIdx] : 1'b0, 1'b1);
            if (oValid) begin
                if (outIdx < nOut) begin
                    checkOutput($sformatf("%s bit%0d", tag, outIdx), int'(oData), int'(outBits[outIdx]));
                end else begin
                    checkOutput($sformatf("%s extraValid", tag), int'(oValid), 0);
                end
                outIdx++;
            end
            if (iValid && oReady) begin
                if (firstAcc < 0) firstAcc = cyc;
                lastAcc = cyc;
                inIdx++;
            end
            cyc++;
        end
        if (cyc >= 200) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL %s budget: got %0d inputs/%0d outputs, expected %0d/%0d",
                     tag, inIdx, outIdx, nIn, nOut);
        end
        checkOutput($sformatf("%s acceptSpan", tag), lastAcc - firstAcc, span);
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
        checkOutput($sformatf("%s drainValid", tag), int'(oValid), 0);
        checkOutput($sformatf("%s drainBusy", tag), int'(oBusy), 0);
    endtask

    initial begin
        // Each frame is listed as: rate, input bits (leftmost first), expected
        // coded bits (leftmost first), accept span.
        frames[0] = '{rate: 2'b00, nIn: 7, inBits: 16'b1000000000000000,
                      nOut: 14, outBits: 16'b1101111100101100, span: 12};
        frames[1] = '{rate: 2'b01, nIn: 4, inBits: 16'b1000000000000000,
                      nOut: 6,  outBits: 16'b1101110000000000, span: 5};
        frames[2] = '{rate: 2'b10, nIn: 6, inBits: 16'b1000000000000000,
                      nOut: 8,  outBits: 16'b1101110000000000, span: 7};
        frames[3] = '{rate: 2'b00, nIn: 4, inBits: 16'b1011000000000000,
                      nOut: 8,  outBits: 16'b1101000100000000, span: 6};
        frames[4] = '{rate: 2'b11, nIn: 2, inBits: 16'b1000000000000000,
                      nOut: 4,  outBits: 16'b1101000000000000, span: 2};

        // Hold reset with active inputs and check that every output is quiet.
        iRst_n = 1'b0;
        iEN    = 1'b1;
        iClear = 1'b0;
        iRate  = 2'b00;
        iData  = 1'b1;
        iValid = 1'b1;
        iReady = 1'b1;
        #12;
        checkOutput("resetValid", int'(oValid), 0);
        checkOutput("resetData",  int'(oData),  0);
        checkOutput("resetBusy",  int'(oBusy),  0);
        checkOutput("resetReady", int'(oReady), 0);
        @(negedge iClk);
        iRst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            clearFrame(frames[v].rate);
            streamBits($sformatf("frame%0d", v), frames[v].nIn, frames[v].inBits,
                       frames[v].nOut, frames[v].outBits, frames[v].span);
        end

        // Backpressure: the first A stays on the output, unchanged, for five
        // stalled cycles. The frame then continues without loss.
        clearFrame(2'b00);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        checkOutput("bpFirstAccept", int'(oReady), 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("bpValid%0d", i), int'(oValid), 1);
            checkOutput($sformatf("bpData%0d", i),  int'(oData),  1);
            checkOutput($sformatf("bpReady%0d", i), int'(oReady), 0);
        end
        streamBits("bpResume", 6, 16'b0000000000000000, 14, 16'b1101111100101100, 10);

        // Mid-frame clear with only B left pending. The clear discards B and
        // latches rate 3/4, so the next impulse starts at phase 0.
        clearFrame(2'b00);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("clrFirstA", int'(oData), 1);
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
        checkOutput("clrReadyLow", int'(oReady), 0);
        checkOutput("clrBusyBefore", int'(oBusy), 1);
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
        checkOutput("clrValidAfter", int'(oValid), 0);
        checkOutput("clrBusyAfter", int'(oBusy), 0);
        streamBits("clrRate34", 6, 16'b1000000000000000, 8, 16'b1101110000000000, 7);

        // Enable freeze: the block is disabled while B of the first pair is
        // still held. The output resumes with that B when enabled again.
        clearFrame(2'b00);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("enFirstA", int'(oData), 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
            checkOutput($sformatf("enOffValid%0d", i), int'(oValid), 0);
            checkOutput($sformatf("enOffReady%0d", i), int'(oReady), 0);
            checkOutput($sformatf("enOffBusy%0d", i),  int'(oBusy),  1);
        end
        streamBits("enResume", 6, 16'b0000000000000000, 13, 16'b1011111001011000, 10);

        // Mid-frame reset at rate 3/4: the outputs drop at once. After reset
        // an unclear'd frame encodes at rate 1/2 from an empty history.
        clearFrame(2'b10);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0);
        @(negedge iClk);
        iValid = 1'b0;
        #2;
        iRst_n = 1'b0;
        #1;
        checkOutput("rstMidValid", int'(oValid), 0);
        checkOutput("rstMidBusy",  int'(oBusy),  0);
        checkOutput("rstMidReady", int'(oReady), 0);
        @(negedge iClk);
        iRst_n = 1'b1;
        streamBits("rstRate12", 7, 16'b1000000000000000, 14, 16'b1101111100101100, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/conv_encoder_punct.md
Name: conv_encoder_punct

Overview:
- Transmit-side counterpart of the Viterbi decoder chain: 802.11a K=7 convolutional encoder (g0=133o, g1=171o) with puncturing to rates 1/2, 2/3 and 3/4.
- Accepts one serial data bit per input handshake and emits the coded/punctured serial bit stream on an output valid/ready handshake.
- Sits between the scrambler/data source and the interleaver.

Parameters:
- K, 7, constraint length; fixed, shift register is K-1 = 6 bits.
- G0, 7'o133, generator polynomial for coded bit A.
- G1, 7'o171, generator polynomial for coded bit B.

Ports:
- iClk  input  1  clock, all logic on rising edge
- iRst_n  input  1  reset, asynchronous, active-low
- iEN  input  1  global enable; low freezes all state
- iClear  input  1  frame start: synchronous clear of state, latches iRate
- iRate  input  2  00=1/2, 01=2/3, 10=3/4, 11 reserved (treated as 1/2)
- iData  input  1  serial data bit
- iValid  input  1  iData valid
- oReady  output  1  encoder can accept iData this cycle (combinational)
- oData  output  1  coded serial bit
- oValid  output  1  oData valid
- iReady  input  1  downstream accepts oData
- oBusy  output  1  coded bits still pending in holding buffer

Behaviour:
- Reset (iRst_n=0, async): shift register 0, phase 0, rate register 00, holding buffer empty; oValid=0, oData=0, oBusy=0, oReady=0 while in reset.
- Encoding, with s[0] = newest previous bit and s[5] = oldest:
  - A = d^s[1]^s[2]^s[4]^s[5]
  - B = d^s[0]^s[1]^s[2]^s[5]
  - On accept, s <= {s[4:0], d}.
- Puncture phase counter advances once per accepted input bit. Wraps at 2 for rate 2/3, at 3 for rate 3/4; held at 0 for rate 1/2.
- Per-phase emission:
  - Rate 1/2: A, B.
  - Rate 2/3: phase0 A, B; phase1 A only.
  - Rate 3/4: phase0 A, B; phase1 A only; phase2 B only.
- Holding buffer: bufA/bufB plus pendA/pendB flags, loaded on accept per the puncture mask. A is always emitted before B.
- Output handshake:
  - oData = pendA ? bufA : bufB.
  - oValid = iEN & (pendA | pendB).
  - A bit is consumed on oValid & iReady. oData must stay stable while oValid=1 and iReady=0.
- Input handshake:
  - oReady = iEN & ~iClear & (buffer empty, or exactly one bit pending and consumed this cycle).
  - Accept on iValid & oReady. Back-to-back accepts are allowed.
- Latency: bit accepted at edge N; first coded bit valid after edge N.
- Throughput (iReady held 1): rate 1/2 → 1 input per 2 cycles; rate 2/3 → 2 inputs per 3 cycles; rate 3/4 → 3 inputs per 4 cycles.
- iClear (needs iEN=1):
  - Clears shift register, phase and buffer; latches iRate; oReady=0 that cycle.
  - Dominates any pending output: pending bits are discarded and oValid drops the next cycle.
- iRate is ignored outside iClear. A mid-frame change has no effect.
- iEN=0: oValid=0 and oReady=0; all registers hold, including buffered bits. Output resumes unchanged when iEN returns.
- oBusy = pendA | pendB (registered state; not gated by iEN).
- Reset mid-frame: immediate return to reset values; no partial bits emitted afterward.

Decomposition:
- Package conv_enc_pkg:
  - G0/G1 constants.
  - Rate codes RATE_1_2/RATE_2_3/RATE_3_4.
  - Puncture-mask function (rate, phase) → {keepA, keepB}.
  - Phase wrap limits.
- One natural sub-module, conv_k7_core: 6-bit shift register + generator XORs, with shift-enable and clear. The top level owns the phase counter, holding buffer and handshakes.

Test Plan:
- Rate 1/2 impulse: iClear with iRate=00, then iData 1 followed by six 0s, iReady=1 → oData sequence 1,1,0,1,1,1,1,1,0,0,1,0,1,1; one input accepted every 2 cycles.
- Rate 2/3 impulse: iRate=01, inputs 1,0,0,0 → oData 1,1,0,1,1,1 (6 bits); phase wraps 0,1,0,1.
- Rate 3/4 impulse: iRate=10, inputs 1,0,0,0,0,0 → oData 1,1,0,1,1,1,0,0 (8 bits); oReady pattern gives 3 accepts per 4 cycles.
- Backpressure: rate 1/2, iReady=0 for 5 cycles after the first oValid → oValid stays 1, oData stable, oReady=0; sequence continues intact on release.
- iClear mid-frame with one bit pending and iRate=10 → pending bit dropped, oValid=0 next cycle; a following impulse produces the rate-3/4 pattern from phase 0.
- iEN low for 3 cycles mid-frame, and iRst_n pulse mid-frame → freeze then resume without loss; reset forces oValid=0, oBusy=0 and rate 1/2 asynchronously.
